// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a
// time and buffers returned instructions with their PC in a small FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ireq,
  input  logic        igrant,
  input  logic        irvalid,
  input  logic [31:0] idata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            fault;
  logic [31:0]     fifo_instr [DEPTH];
  logic [31:0]     fifo_pc    [DEPTH];

  logic accept;
  logic pop;
  logic push;

  // A request only goes out when a FIFO slot is free, so a later push never overflows.
  assign ireq        = (state == IDLE) && (count < CW'(DEPTH)) && !fault && !reset;
  assign accept      = ireq && igrant;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == WAIT) && irvalid && !redirect;
  assign iaddr       = pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign fetch_fault = fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fault  <= 1'b0;
    end else if (redirect) begin
      // Flush; any response still owed by memory is drained through DROP.
      pc     <= {redirect_pc[31:2], 2'b00};
      fault  <= |redirect_pc[1:0];
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      case (state)
        IDLE:    if (accept) state <= DROP;
        WAIT:    state <= irvalid ? IDLE : DROP;
        DROP:    if (irvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT:    if (irvalid) state <= IDLE;
        DROP:    if (irvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) begin
        fifo_instr[wr_ptr] <= idata;
        fifo_pc[wr_ptr]    <= req_pc;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
